// File: rtl/mips_pkg.sv
// Shared fetch-side types: FSM state encoding and the default reset PC.
// Pure declarations; no latency or backpressure of its own.
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection for the held instruction: sequential, PC-relative branch, or jump.
// Purely combinational, zero latency; no backpressure (evaluated every cycle, used on consume).
module pc_next_logic (
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic        branch,
  input  logic        blez,
  input  logic        jump,
  input  logic        zero,
  input  logic        lez,
  output logic [31:0] pcplus4,
  output logic [31:0] next_pc
);

  logic [29:0] imm_words;
  logic [29:0] branch_word;
  logic        taken;

  always_comb begin
    pcplus4 = pc + 32'd4;
    // Work in word units: the low two bits of every target are zero anyway.
    imm_words   = {{14{instr_idx[15]}}, instr_idx[15:0]};
    branch_word = pcplus4[31:2] + imm_words;
    taken       = (branch & zero) | (blez & lez);

    next_pc = {pcplus4[31:2], 2'b00};
    if (jump) begin
      next_pc = {pcplus4[31:28], instr_idx, 2'b00};
    end else if (taken) begin
      next_pc = {branch_word, 2'b00};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests imem at pc, holds the returned word until the decoder consumes it.
// Latency: instr_valid one cycle after imem_rvalid, new request one cycle after consume; stalls in HOLD while instr_ready=0.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        blez,
  input  logic        jump,
  input  logic        zero,
  input  logic        lez,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic         capture;
  logic         consume;
  logic [31:0]  next_pc;

  pc_next_logic u_pc_next (
    .pc        (pc),
    .instr_idx (instr[25:0]),
    .branch    (branch),
    .blez      (blez),
    .jump      (jump),
    .zero      (zero),
    .lez       (lez),
    .pcplus4   (pcplus4),
    .next_pc   (next_pc)
  );

  assign imem_addr = pc;

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    consume     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          consume   = 1'b1;
          state_nxt = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= {RESET_PC[31:2], 2'b00};
      instr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        instr <= imem_rdata;
      end
      if (consume) begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port: imem_addr  output  32  byte address of requested instruction (= pc).
REQ-006 SHALL have port: imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  instruction word from memory.
REQ-008 SHALL have port: instr  output  32  held instruction register to the decoder.
REQ-009 SHALL have port: instr_valid  output  1  instr holds an unconsumed instruction.
REQ-010 SHALL have port: instr_ready  input  1  decoder/datapath consumes instr this cycle.
REQ-011 SHALL have ports: branch, blez, jump  input  1 each  decoder control outputs for the held instruction.
REQ-012 SHALL have ports: zero, lez  input  1 each  ALU flags: result zero; srca <= 0 (signed).
REQ-013 SHALL have ports: pc, pcplus4  output  32 each  address of held instruction and pc+4.

Function
REQ-014 SHALL implement two states: FETCH (imem_req=1, instr_valid=0) and HOLD (imem_req=0, instr_valid=1).
REQ-015 In FETCH with imem_rvalid=1, SHALL capture imem_rdata into instr and move to HOLD next cycle; else stay in FETCH.
REQ-016 In HOLD, imem_rvalid SHALL be ignored and instr SHALL stay unchanged.
REQ-017 In HOLD with instr_ready=1, SHALL load pc with next_pc and move to FETCH; else stay in HOLD with pc unchanged.
REQ-018 instr_ready in FETCH SHALL be ignored.
REQ-019 branch, blez, jump, zero, lez SHALL be sampled only in the consume cycle (HOLD & instr_ready).
REQ-020 pcplus4 SHALL be pc + 4 modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-021 signimm SHALL be the sign-extended instr[15:0]; branch target SHALL be pcplus4 + (signimm << 2) modulo 2^32.
REQ-022 taken SHALL be (branch & zero) | (blez & lez).
REQ-023 next_pc SHALL be {pcplus4[31:28], instr[25:0], 2'b00} if jump=1, else branch target if taken=1, else pcplus4; jump has priority over taken.
REQ-024 pc[1:0] SHALL always be 2'b00; next_pc[1:0] SHALL be forced to 00.
REQ-025 Fetch-to-valid latency SHALL be one cycle after imem_rvalid; consume-to-new-request latency SHALL be one cycle; minimum throughput is one instruction per 2 cycles with zero-wait memory.

Reset
REQ-026 On reset: pc=RESET_PC, state=FETCH, instr=32'h0, instr_valid=0, imem_req=1 on the cycle after reset is sampled.
REQ-027 Reset SHALL override any simultaneous imem_rvalid or instr_ready; an in-flight response is dropped, and imem shares the reset so it returns no stale data.
REQ-028 Reset asserted mid-HOLD SHALL discard instr and restart fetch at RESET_PC.

Structure
REQ-029 State enum (FETCH, HOLD) and default RESET_PC SHALL live in shared package mips_pkg.
REQ-030 Next-PC selection (REQ-020..REQ-024) SHALL be a combinational sub-module pc_next_logic; fetch_unit holds only the FSM, pc and instr registers.

Verification
REQ-031 Sequential: reset, zero-wait imem, instr_ready=1, no control -> imem_addr 0x0, 0x4, 0x8 on successive fetches; instr_valid every 2nd cycle.
REQ-032 Backpressure: hold instr_ready=0 for 5 cycles in HOLD with imem_rvalid pulsing -> instr, pc stable, imem_req=0; then ready=1 -> next pc=pc+4.
REQ-033 Branch: pc=0x10, instr[15:0]=0xFFFC, branch=1, zero=1 -> next pc=0x04; same with zero=0 -> 0x14; blez=1, lez=1, imm=0x0002 -> 0x1C.
REQ-034 Jump priority: pc=0x4000_0020, instr[25:0]=0x0000100, jump=1, branch=1, zero=1 -> next pc=0x4000_0400.
REQ-035 Wrap: pc=0xFFFF_FFFC, no control -> next pc=0x0000_0000.
REQ-036 Reset mid-op: assert reset in HOLD with instr_ready=1 and in FETCH with imem_rvalid=1 -> pc=RESET_PC, instr_valid=0, state=FETCH.
